// File: rtl/multi_phase_traffic_controller.sv
// multi_phase_traffic_controller
//   Demand-actuated N-phase traffic signal controller. Phases are served in
//   round-robin order, skipping phases with no latched demand. Green is bounded
//   by MIN_GREEN/MAX_GREEN with gap-out, every change of right-of-way passes
//   through yellow and all-red, and a flash mode overrides normal sequencing.
//
// Ports
//   i_clk          : clock, rising edge
//   i_reset_n      : synchronous active-low reset
//   i_demand       : per-phase vehicle detect (level)
//   i_flash_en     : flash mode request (level)
//   o_lights       : phase i lamps on [3i+2:3i]; RED=100 YELLOW=010 GREEN=001 OFF=000
//   o_active_phase : phase owning (or last owning) right-of-way
//   o_ctrl_state   : GREEN=00 YELLOW=01 ALL_RED=10 FLASH=11
//   o_green_start  : one-cycle pulse in the first cycle of every green

module multi_phase_traffic_controller #(
  parameter int unsigned NUM_PHASES   = 4,
  parameter int unsigned PHASE_W      = 2,
  parameter int unsigned TIMER_W      = 8,
  parameter int unsigned MIN_GREEN    = 20,
  parameter int unsigned MAX_GREEN    = 50,
  parameter int unsigned YELLOW_TIME  = 10,
  parameter int unsigned ALL_RED_TIME = 2,
  parameter int unsigned FLASH_HALF   = 25
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [NUM_PHASES-1:0]   i_demand,
  input  logic                    i_flash_en,
  output logic [3*NUM_PHASES-1:0] o_lights,
  output logic [PHASE_W-1:0]      o_active_phase,
  output logic [1:0]              o_ctrl_state,
  output logic                    o_green_start
);

  typedef enum logic [1:0] {
    StGreen  = 2'b00,
    StYellow = 2'b01,
    StAllRed = 2'b10,
    StFlash  = 2'b11
  } state_e;

  localparam logic [TIMER_W-1:0] LP_MIN_M1   = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] LP_MAX_M1   = TIMER_W'(MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] LP_YEL_M1   = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] LP_AR_M1    = TIMER_W'(ALL_RED_TIME - 1);
  localparam logic [TIMER_W-1:0] LP_FLASH_M1 = TIMER_W'(FLASH_HALF - 1);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  state_e                  r_state;
  logic [PHASE_W-1:0]      r_cur;
  logic [TIMER_W-1:0]      r_timer;
  logic [NUM_PHASES-1:0]   r_pending;
  logic                    r_flash_on;
  logic                    r_green_start;

  logic [NUM_PHASES-1:0]   w_cur_mask;
  logic [NUM_PHASES-1:0]   w_next_mask;
  logic [NUM_PHASES-1:0]   w_pending_set;
  logic [PHASE_W-1:0]      w_next;
  logic [7:0]              w_best_dist;
  logic                    w_others;
  logic                    w_cur_demand;
  logic                    w_cur_valid;
  logic                    w_leave_green;

  // Search distance from cur: cur+1 -> 0, ..., cur itself -> NUM_PHASES-1 (searched last).
  function automatic logic [7:0] f_dist(input int unsigned idx, input int unsigned cur);
    return 8'((idx + NUM_PHASES - 1 - cur) % NUM_PHASES);
  endfunction

  always_comb begin
    w_cur_mask  = '0;
    w_next_mask = '0;
    w_best_dist = 8'hFF;
    w_next      = (32'(r_cur) >= NUM_PHASES - 1) ? '0 : r_cur + PHASE_W'(1);
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      w_cur_mask[i] = (32'(r_cur) == i);
      if (r_pending[i] && (f_dist(i, 32'(r_cur)) < w_best_dist)) begin
        w_best_dist = f_dist(i, 32'(r_cur));
        w_next      = PHASE_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      w_next_mask[i] = (32'(w_next) == i);
    end
  end

  assign w_cur_valid   = (32'(r_cur) < NUM_PHASES);
  assign w_others      = |(r_pending & ~w_cur_mask);
  assign w_cur_demand  = |(i_demand & w_cur_mask);
  // Demand on the phase that is currently green is already being served.
  assign w_pending_set = r_pending |
                         (i_demand & ~((r_state == StGreen) ? w_cur_mask : '0));
  assign w_leave_green = w_others &&
                         ((r_timer == LP_MAX_M1) ||
                          ((r_timer >= LP_MIN_M1) && !w_cur_demand));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state       <= StGreen;
      r_cur         <= '0;
      r_timer       <= '0;
      r_pending     <= '0;
      r_flash_on    <= 1'b0;
      r_green_start <= 1'b0;
    end else begin
      r_green_start <= 1'b0;
      r_pending     <= w_pending_set;
      if (i_flash_en) begin
        if (r_state != StFlash) begin
          r_state    <= StFlash;
          r_timer    <= '0;
          r_flash_on <= 1'b1;
        end else if (r_timer == LP_FLASH_M1) begin
          r_timer    <= '0;
          r_flash_on <= ~r_flash_on;
        end else begin
          r_timer <= r_timer + TIMER_W'(1);
        end
      end else begin
        case (r_state)
          StGreen: begin
            if (w_leave_green) begin
              r_state <= StYellow;
              r_timer <= '0;
            end else if (r_timer != LP_MAX_M1) begin
              r_timer <= r_timer + TIMER_W'(1);
            end
          end
          StYellow: begin
            if (r_timer == LP_YEL_M1) begin
              r_state <= StAllRed;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + TIMER_W'(1);
            end
          end
          StAllRed: begin
            if (r_timer == LP_AR_M1) begin
              r_state       <= StGreen;
              r_timer       <= '0;
              r_cur         <= w_next;
              r_green_start <= 1'b1;
              // Entering green clears that phase's request, winning over a new set.
              r_pending     <= w_pending_set & ~w_next_mask;
            end else begin
              r_timer <= r_timer + TIMER_W'(1);
            end
          end
          StFlash: begin
            r_state <= StAllRed;
            r_timer <= '0;
          end
          default: begin
            r_state <= StAllRed;
            r_timer <= '0;
          end
        endcase
      end
      if (!w_cur_valid) begin
        r_cur <= '0;
      end
    end
  end

  always_comb begin
    o_lights = '0;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      case (r_state)
        StGreen:  o_lights[3*i +: 3] = w_cur_mask[i] ? LAMP_GREEN : LAMP_RED;
        StYellow: o_lights[3*i +: 3] = w_cur_mask[i] ? LAMP_YELLOW : LAMP_RED;
        StAllRed: o_lights[3*i +: 3] = LAMP_RED;
        StFlash:  o_lights[3*i +: 3] = r_flash_on ? LAMP_RED : LAMP_OFF;
        default:  o_lights[3*i +: 3] = LAMP_RED;
      endcase
    end
  end

  assign o_active_phase = r_cur;
  assign o_ctrl_state   = r_state;
  assign o_green_start  = r_green_start;

endmodule

// File: doc/multi_phase_traffic_controller.md
# multi_phase_traffic_controller

Parametrised N-phase, demand-actuated traffic signal controller. It is the next generation of the fixed two-direction controller. It serves `NUM_PHASES` approaches in round-robin order and skips phases with no pending demand. Green time is bounded by a minimum and a maximum, with gap-out extension. Every change of right-of-way passes through yellow and then an all-red clearance interval. A flash mode overrides normal operation for maintenance or fault conditions. It sits between the per-approach vehicle sensors and the lamp driver outputs.

## Interface
- `NUM_PHASES`, 4: number of approaches/phases, 2..8.
- `PHASE_W`, 2: width of phase index; must be ≥ clog2(NUM_PHASES).
- `TIMER_W`, 8: phase timer width; every time parameter must be ≤ 2^TIMER_W − 1.
- `MIN_GREEN`, 20: minimum green cycles, ≥ 1.
- `MAX_GREEN`, 50: maximum green cycles while another phase is waiting, ≥ MIN_GREEN.
- `YELLOW_TIME`, 10: yellow cycles, ≥ 1.
- `ALL_RED_TIME`, 2: all-red clearance cycles, ≥ 1.
- `FLASH_HALF`, 25: flash half-period in cycles, ≥ 1.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `demand` in NUM_PHASES: per-phase vehicle detect, level, sampled each edge.
- `flash_en` in 1: flash mode request, level.
- `lights` out 3*NUM_PHASES: phase i on bits [3i+2:3i]; RED=100, YELLOW=010, GREEN=001, OFF=000.
- `active_phase` out PHASE_W: phase currently owning right-of-way (last green).
- `ctrl_state` out 2: GREEN=00, YELLOW=01, ALL_RED=10, FLASH=11.
- `green_start` out 1: one-cycle pulse in the first cycle of every green.

## Operation
- Registered state:
  - `state`
  - `cur` (phase index)
  - `timer` (TIMER_W)
  - `pending[NUM_PHASES]`
  - `flash_on`
  - `green_start`
- Priority: reset > flash_en > normal sequencing.
- Pending latch: `pending[i]` is set on any edge where `demand[i]`=1. It is cleared on the edge that enters GREEN of phase i; that clear wins over a simultaneous set. Demand on `cur` while it is green is not latched.
- `others` = OR of `pending[j]` for j ≠ cur.
- GREEN: `timer` increments, saturating at MAX_GREEN−1. The controller leaves for YELLOW (timer←0) when `others` is 1 AND either of these holds:
  - timer == MAX_GREEN−1 (max-out);
  - timer ≥ MIN_GREEN−1 and demand[cur]==0 (gap-out).
- Rest in green: with `others`=0 the controller stays in GREEN indefinitely.
- YELLOW: the light for `cur` is YELLOW. At timer == YELLOW_TIME−1 → ALL_RED, timer←0.
- ALL_RED: all lights RED. At timer == ALL_RED_TIME−1 → GREEN of the next phase, timer←0, green_start←1, pending[next]←0.
  - next = first index with pending set, searching cur+1, cur+2, … wrapping modulo NUM_PHASES, with cur itself searched last.
  - If nothing is pending, next = (cur+1) mod NUM_PHASES.
- FLASH: entered on the edge after flash_en is sampled 1, from any state. On entry, timer←0 and flash_on←1.
  - Every lamp shows RED when flash_on=1 and OFF when flash_on=0.
  - flash_on toggles and timer←0 when timer == FLASH_HALF−1.
  - Pending keeps latching during FLASH.
  - On the edge where flash_en is sampled 0, the controller goes to ALL_RED with timer←0 and cur unchanged.
- Lights and ctrl_state decode combinationally from registered state. Non-active phases are RED in GREEN and YELLOW states.
- Illegal state encodings recover to ALL_RED on the next edge. If cur ≥ NUM_PHASES, cur←0.

## Timing
- Reset (reset_n=0 at an edge):
  - state=GREEN, cur=0, timer=0, pending=0, flash_on=0, green_start=0.
  - Outputs: lights = phase 0 GREEN, all others RED; active_phase=0; ctrl_state=00.
- Reset mid-operation takes effect only at the next clk edge; it is not asynchronous.
- Durations, in cycles:
  - Yellow: exactly YELLOW_TIME.
  - All-red: exactly ALL_RED_TIME.
  - Green with others pending: between MIN_GREEN and MAX_GREEN inclusive.
- Demand-to-service latency: a demand sampled at edge k is pending from k+1 and can terminate the current green no earlier than the MIN_GREEN bound.
- A flash_en change is reflected on lights one cycle after it is sampled.
- green_start is high for exactly the first GREEN cycle. It is not asserted out of reset.

## Test plan
All tests use NUM_PHASES=4, MIN_GREEN=4, MAX_GREEN=10, YELLOW_TIME=2, ALL_RED_TIME=1, FLASH_HALF=3.
- Reset release, demand=0 for 100 cycles → lights=100_100_100_001 every cycle, ctrl_state=00.
- One-cycle pulse on demand[2] with demand[0]=0 → phase 0 green for 4 cycles, then 2 yellow, then 1 all-red, then phase 2 green with a green_start pulse. Phase 1 is never green.
- demand[0] held at 1 with demand[1] pending → phase 0 green for exactly 10 cycles (max-out). If instead demand[0] drops at green cycle 6, the green ends after cycle 6 (gap-out).
- cur=3 with pending={0,2} → next green is phase 0. Then phase 2 follows after a full green, yellow and all-red sequence.
- flash_en raised during YELLOW → next cycle all lamps 100 for 3 cycles, then 000 for 3 cycles, repeating. Dropping flash_en → 1 all-red cycle, then green of the next pending phase.
- reset_n pulsed low for one edge during an EW-equivalent green (cur=1) → next cycle state is exactly the reset values above, and pending is cleared.
